// File: rtl/openmips_rst_ctrl.sv
// Reset/run sequencer for the openMIPS minimal SoC: synchronizes board reset release,
// holds the CPU in reset for a fixed time, runs it and optionally halts it after a budget.
//
// state | meaning
// RESET | board reset active or release not yet synchronized, cpu_rst high
// HOLD  | synchronized release seen, cpu_rst held high for the hold time
// RUN   | CPU running, run_cnt counting
// HALT  | run budget exhausted, CPU frozen in reset until halt_clr or soft reset
module openmips_rst_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 10,
    parameter int RUN_LIMIT   = 50,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst_req,
    input  logic             halt_clr,
    output logic             cpu_rst,
    output logic             cpu_run,
    output logic             halted,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] run_cnt
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int HOLD_N = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int HOLD_W = $clog2(HOLD_N + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_N - 1);
    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(RUN_LIMIT);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_HOLD  = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state;
    logic [SYNC_N-1:0] sync_q;
    logic              rst_sync;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  run_inc;
    logic              restart;

    assign rst_sync = sync_q[SYNC_N-1];
    assign state_o  = state;

    // Saturating increment so an unlimited run never wraps back to zero.
    assign run_inc = (run_cnt == '1) ? run_cnt : run_cnt + CNT_W'(1);

    assign restart = (state != S_RESET) &&
                     (soft_rst_req || ((state == S_HALT) && halt_clr));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_RESET;
            cpu_rst  <= 1'b1;
            cpu_run  <= 1'b0;
            halted   <= 1'b0;
            run_cnt  <= '0;
            hold_cnt <= '0;
        end else if (restart) begin
            state    <= S_HOLD;
            cpu_rst  <= 1'b1;
            cpu_run  <= 1'b0;
            halted   <= 1'b0;
            run_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (rst_sync) begin
                        state    <= S_HOLD;
                        hold_cnt <= '0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state   <= S_RUN;
                        cpu_rst <= 1'b0;
                        cpu_run <= 1'b1;
                        run_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    run_cnt <= run_inc;
                    if ((RUN_LIMIT != 0) && (run_inc == RUN_LAST)) begin
                        state   <= S_HALT;
                        cpu_rst <= 1'b1;
                        cpu_run <= 1'b0;
                        halted  <= 1'b1;
                    end
                end
                S_HALT: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_openmips_rst_ctrl.sv
// Scoreboard bench for openmips_rst_ctrl: stimulus queues hand-computed expectations
// tagged with the clock edge they apply to; a monitor pops and compares them.
module tb_openmips_rst_ctrl;

    logic       clk = 1'b0;
    logic       rst, soft_rst_req, halt_clr;
    logic       cpu_rst, cpu_run, halted;
    logic [1:0] state_o;
    logic [31:0] run_cnt;

    logic       rst2, soft2, hclr2;
    logic       cpu_rst2, cpu_run2, halted2;
    logic [1:0] state2;
    logic [3:0] run_cnt2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    event probe_ev;

    typedef struct {
        int          at;
        int          dut;
        logic [1:0]  st;
        logic        crst;
        logic        crun;
        logic        hlt;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t q[$];

    openmips_rst_ctrl dut (
        .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req), .halt_clr(halt_clr),
        .cpu_rst(cpu_rst), .cpu_run(cpu_run), .halted(halted),
        .state_o(state_o), .run_cnt(run_cnt)
    );

    openmips_rst_ctrl #(.SYNC_STAGES(2), .HOLD_CYCLES(0), .RUN_LIMIT(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst2), .soft_rst_req(soft2), .halt_clr(hclr2),
        .cpu_rst(cpu_rst2), .cpu_run(cpu_run2), .halted(halted2),
        .state_o(state2), .run_cnt(run_cnt2)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int at, input int d, input logic [1:0] st,
                             input logic crst, input logic crun, input logic hlt,
                             input logic [31:0] cnt, input string name);
        exp_t e;
        e.at = at; e.dut = d; e.st = st; e.crst = crst; e.crun = crun;
        e.hlt = hlt; e.cnt = cnt; e.name = name;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < n);
    endtask

    // Expected sequence after a release of dut with default parameters (edge k = b+k).
    task automatic expect_startup(input int b);
        expect_at(b + 1,  1, 2'd0, 1, 0, 0, 0,  "sync_e1");
        expect_at(b + 2,  1, 2'd0, 1, 0, 0, 0,  "sync_e2");
        expect_at(b + 3,  1, 2'd1, 1, 0, 0, 0,  "hold_e3");
        expect_at(b + 12, 1, 2'd1, 1, 0, 0, 0,  "hold_e12");
        expect_at(b + 13, 1, 2'd2, 0, 1, 0, 0,  "run_e13");
        expect_at(b + 14, 1, 2'd2, 0, 1, 0, 1,  "run_e14");
        expect_at(b + 62, 1, 2'd2, 0, 1, 0, 49, "run_e62");
        expect_at(b + 63, 1, 2'd3, 1, 0, 1, 50, "halt_e63");
    endtask

    // Monitor
    initial begin
        exp_t e;
        logic [1:0]  g_st;
        logic        g_rst, g_run, g_hlt;
        logic [31:0] g_cnt;
        forever begin
            @(negedge clk or probe_ev);
            while (q.size() > 0 && (q[0].at == -1 || q[0].at == cyc)) begin
                e = q.pop_front();
                if (e.dut == 1) begin
                    g_st = state_o; g_rst = cpu_rst; g_run = cpu_run; g_hlt = halted; g_cnt = run_cnt;
                end else begin
                    g_st = state2; g_rst = cpu_rst2; g_run = cpu_run2; g_hlt = halted2;
                    g_cnt = {28'd0, run_cnt2};
                end
                checks++;
                if ({g_st, g_rst, g_run, g_hlt, g_cnt} !== {e.st, e.crst, e.crun, e.hlt, e.cnt}) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got state=%0d cpu_rst=%0b cpu_run=%0b halted=%0b run_cnt=%0d expected state=%0d cpu_rst=%0b cpu_run=%0b halted=%0b run_cnt=%0d",
                             e.name, cyc, g_st, g_rst, g_run, g_hlt, g_cnt,
                             e.st, e.crst, e.crun, e.hlt, e.cnt);
                end
            end
            while (q.size() > 0 && q[0].at != -1 && q[0].at < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL %s never compared: due cyc=%0d now cyc=%0d", e.name, e.at, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Stimulus
    initial begin
        int base;
        int b2;
        rst = 1'b0; soft_rst_req = 1'b0; halt_clr = 1'b0;
        rst2 = 1'b0; soft2 = 1'b0; hclr2 = 1'b0;

        // Scenario 1: held in reset, then release at 195 ns (between edges)
        for (int i = 1; i <= 10; i++) begin
            expect_at(i, 1, 2'd0, 1, 0, 0, 0, "in_reset");
            if (i == 5) expect_at(i, 2, 2'd0, 1, 0, 0, 0, "dut2_in_reset");
        end
        #195;
        rst = 1'b1;
        base = cyc;
        expect_startup(base);

        // Scenario 2: HALT holds for 20 further cycles
        for (int k = 64; k <= 83; k++)
            expect_at(base + k, 1, 2'd3, 1, 0, 1, 50, "halt_hold");

        // Scenario 3: halt_clr restarts; halt_clr in RUN is ignored
        expect_at(base + 85,  1, 2'd1, 1, 0, 0, 0, "halt_clr_hold");
        expect_at(base + 94,  1, 2'd1, 1, 0, 0, 0, "halt_clr_hold_e9");
        expect_at(base + 95,  1, 2'd2, 0, 1, 0, 0, "halt_clr_run");
        expect_at(base + 101, 1, 2'd2, 0, 1, 0, 6, "halt_clr_in_run_ignored");
        wait_cyc(base + 84);  halt_clr = 1'b1;
        wait_cyc(base + 85);  halt_clr = 1'b0;
        wait_cyc(base + 100); halt_clr = 1'b1;
        wait_cyc(base + 101); halt_clr = 1'b0;

        // Scenario 4: soft reset mid-run and on the would-be halt edge
        expect_at(base + 115, 1, 2'd2, 0, 1, 0, 20, "run_cnt20");
        expect_at(base + 116, 1, 2'd1, 1, 0, 0, 0,  "soft_hold");
        expect_at(base + 126, 1, 2'd2, 0, 1, 0, 0,  "soft_rerun");
        expect_at(base + 175, 1, 2'd2, 0, 1, 0, 49, "run_cnt49");
        expect_at(base + 176, 1, 2'd1, 1, 0, 0, 0,  "soft_beats_halt");
        expect_at(base + 177, 1, 2'd1, 1, 0, 0, 0,  "soft_beats_halt_e2");
        expect_at(base + 236, 1, 2'd3, 1, 0, 1, 50, "halt_again");
        expect_at(base + 241, 1, 2'd1, 1, 0, 0, 0,  "both_req_hold");
        expect_at(base + 250, 1, 2'd1, 1, 0, 0, 0,  "both_req_hold_e9");
        expect_at(base + 251, 1, 2'd2, 0, 1, 0, 0,  "both_req_run");
        expect_at(base + 260, 1, 2'd2, 0, 1, 0, 9,  "run_before_drop");
        wait_cyc(base + 115); soft_rst_req = 1'b1;
        wait_cyc(base + 116); soft_rst_req = 1'b0;
        wait_cyc(base + 175); soft_rst_req = 1'b1;
        wait_cyc(base + 176); soft_rst_req = 1'b0;
        wait_cyc(base + 240); soft_rst_req = 1'b1; halt_clr = 1'b1;
        wait_cyc(base + 241); soft_rst_req = 1'b0; halt_clr = 1'b0;

        // Scenario 5: asynchronous reset mid-run, between edges
        wait_cyc(base + 261);
        #4;
        rst = 1'b0;
        #1;
        expect_at(-1, 1, 2'd0, 1, 0, 0, 0, "async_reset");
        expect_at(base + 262, 1, 2'd0, 1, 0, 0, 0, "reset_held_a");
        expect_at(base + 263, 1, 2'd0, 1, 0, 0, 0, "reset_held_b");
        ->probe_ev;
        wait_cyc(base + 264);
        #4;
        rst = 1'b1;
        base = cyc;
        expect_startup(base);
        for (int k = 64; k <= 66; k++)
            expect_at(base + k, 1, 2'd3, 1, 0, 1, 50, "halt_hold_2");
        wait_cyc(base + 66);

        // Scenario 6: HOLD_CYCLES=0, RUN_LIMIT=0, CNT_W=4
        #4;
        rst2 = 1'b1;
        b2 = cyc;
        expect_at(b2 + 2,  2, 2'd0, 1, 0, 0, 0,  "d2_sync_e2");
        expect_at(b2 + 3,  2, 2'd1, 1, 0, 0, 0,  "d2_hold_e3");
        expect_at(b2 + 4,  2, 2'd2, 0, 1, 0, 0,  "d2_run_e4");
        expect_at(b2 + 5,  2, 2'd2, 0, 1, 0, 1,  "d2_run_e5");
        expect_at(b2 + 18, 2, 2'd2, 0, 1, 0, 14, "d2_cnt14");
        expect_at(b2 + 19, 2, 2'd2, 0, 1, 0, 15, "d2_cnt15");
        for (int k = 20; k <= 24; k++)
            expect_at(b2 + k, 2, 2'd2, 0, 1, 0, 15, "d2_saturated");
        wait_cyc(b2 + 25);
        #20;

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/openmips_rst_ctrl.md
Name: openmips_rst_ctrl

Overview:
Reset and run sequencer for the openMIPS minimal SoC. It is the synthesizable driver for the SoC's clk/rst interface. It accepts the board's asynchronous active-low reset and synchronizes its release. It then holds the CPU in reset for a fixed number of cycles, lets it run, and optionally freezes it after a cycle budget. It sits between the board reset pin and the rst input of openmips_min_sopc.

Parameters:
SYNC_STAGES, 2, number of flops in the reset-release synchronizer (minimum 2).
HOLD_CYCLES, 10, clk cycles cpu_rst stays asserted after synchronized release. A value of 0 is treated as 1.
RUN_LIMIT, 50, RUN cycles before automatic halt. 0 means run forever.
CNT_W, 32, width of run_cnt.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
soft_rst_req  in  1  synchronous single-cycle request to restart the CPU.
halt_clr  in  1  synchronous request to leave HALT and restart.
cpu_rst  out  1  CPU reset, active-high (`RstEnable` polarity), registered.
cpu_run  out  1  high only in RUN, registered.
halted  out  1  high only in HALT, registered.
state_o  out  2  current state: 0 RESET, 1 HOLD, 2 RUN, 3 HALT.
run_cnt  out  CNT_W  number of RUN cycles since the last entry to HOLD.

Behaviour:
- Reset assertion (rst=0) is asynchronous and immediate for all flops.
  - state=RESET, cpu_rst=1, cpu_run=0, halted=0, run_cnt=0.
  - Synchronizer chain and hold counter are cleared to 0.
- Release synchronizer: a chain of SYNC_STAGES flops shifts in 1 each edge while rst=1. rst_sync is the last stage.
- Edge numbering: edge k is the k-th rising edge after rst deasserts. Deassertion coincident with an edge does not count.
- RESET state: cpu_rst=1. Move to HOLD on the first edge where rst_sync=1, which is edge SYNC_STAGES+1.
- HOLD state:
  - cpu_rst=1; hold counter increments each edge.
  - After max(HOLD_CYCLES,1) edges in HOLD, move to RUN.
  - On that same edge: cpu_rst→0, cpu_run→1, run_cnt=0.
  - With defaults: HOLD at edge 3, RUN and cpu_rst=0 at edge 13.
- RUN state:
  - run_cnt increments by 1 each edge, so after edge 13+n run_cnt=n (defaults).
  - If RUN_LIMIT≠0 and the increment makes run_cnt==RUN_LIMIT, move to HALT on that edge: cpu_rst→1, cpu_run→0, halted→1.
  - With RUN_LIMIT=0, run_cnt saturates at all-ones and never wraps.
- HALT state: cpu_rst=1, halted=1, run_cnt holds its value. halt_clr moves to HOLD.
- soft_rst_req in HOLD, RUN or HALT: next edge moves to HOLD.
  - Hold counter and run_cnt clear; cpu_rst=1, cpu_run=0, halted=0.
  - Ignored in RESET.
- Simultaneous events:
  - soft_rst_req beats the halt transition on the same edge.
  - soft_rst_req together with halt_clr gives a single HOLD entry.
  - halt_clr outside HALT is ignored.
- rst asserted mid-RUN/HOLD/HALT: immediate return to RESET values, no partial state retained. The full sync + HOLD sequence repeats after release.
- Outputs are glitch-free: all driven from flops, with no combinational path from inputs.

Test Plan:
1. Defaults, hold rst=0 for 195 ns on a 20 ns clk, then release.
   - Required: cpu_rst=1 and state_o=0 throughout reset.
   - state_o=1 at edge 3; cpu_rst=0, cpu_run=1, state_o=2 at edge 13.
2. Continue from 1.
   - Required: run_cnt=49 after edge 62.
   - At edge 63: run_cnt=50, state_o=3, halted=1, cpu_rst=1. Values hold for 20 further cycles.
3. From HALT, pulse halt_clr for one cycle.
   - Required: next edge state_o=1, run_cnt=0, halted=0.
   - cpu_rst falls 10 edges later.
4. In RUN at run_cnt=20, pulse soft_rst_req.
   - Required: next edge state_o=1, cpu_rst=1, run_cnt=0.
   - Repeat with the pulse on the edge where run_cnt would reach 50: must enter HOLD, not HALT.
5. Drop rst to 0 mid-RUN, between clock edges.
   - Required: cpu_rst=1, run_cnt=0, state_o=0 immediately, with no clock edge needed.
   - After release, the sequence repeats exactly as in scenario 1.
6. RUN_LIMIT=0, HOLD_CYCLES=0, CNT_W=4.
   - Required: RUN entered at edge 4; run_cnt saturates at 15; state_o stays 2.
